// File: rtl/sram_req_bridge.sv
// Bridges the core's single-cycle data SRAM access onto a valid/ready request/response bus,
// stalling the core while the access is outstanding. Define SRAM_BRIDGE_POSTED_WRITE_EN for posted writes.
module sram_req_bridge #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                cpu_en,
  input  logic [DATA_W/8-1:0] cpu_wen,
  input  logic [ADDR_W-1:0]   cpu_addr,
  input  logic [DATA_W-1:0]   cpu_wdata,
  output logic [DATA_W-1:0]   cpu_rdata,
  output logic                cpu_stall,
  output logic                req_valid,
  input  logic                req_ready,
  output logic                req_wr,
  output logic [DATA_W/8-1:0] req_wstrb,
  output logic [ADDR_W-1:0]   req_addr,
  output logic [DATA_W-1:0]   req_wdata,
  input  logic                resp_valid,
  output logic                resp_ready,
  input  logic [DATA_W-1:0]   resp_rdata,
  output logic                bus_err
);

  localparam int          STRB_W       = DATA_W / 8;
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DONE
  } state_t;

  state_t              state, state_next;
  logic [ADDR_W-1:0]   addr_q;
  logic [STRB_W-1:0]   wen_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   rdata_q;
  logic [15:0]         cnt_q;
  logic                bus_err_q;
  logic                accept;
  logic                handshake;
  logic                resp_take;
  logic                timeout;
  logic                posted;

  assign accept    = (state == IDLE) && cpu_en;
  assign handshake = (state == REQ) && req_ready;
  assign resp_take = (state == WAIT) && resp_valid;
  // A response in the last allowed cycle beats the timeout.
  assign timeout   = (state == WAIT) && !resp_valid && (cnt_q == TIMEOUT_LAST);
  assign posted    = |wen_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    // NOTE: default first so no path through the case leaves state_next unassigned (no latch).
    state_next = state;
    unique case (state)
      IDLE: if (cpu_en) state_next = REQ;
      REQ:  if (req_ready) state_next = WAIT;
      WAIT: if (resp_valid || timeout) state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    req_valid  = (state == REQ);
    resp_ready = (state == WAIT);
`ifdef SRAM_BRIDGE_POSTED_WRITE_EN
    // A posted write frees the core; any new access waits for IDLE to be accepted.
    unique case (state)
      IDLE:      cpu_stall = cpu_en && !(|cpu_wen);
      REQ, WAIT: cpu_stall = posted ? cpu_en : 1'b1;
      DONE:      cpu_stall = posted && cpu_en;
      default:   cpu_stall = 1'b0;
    endcase
`else
    unique case (state)
      IDLE:      cpu_stall = cpu_en;
      REQ, WAIT: cpu_stall = 1'b1;
      default:   cpu_stall = 1'b0;
    endcase
`endif
  end

  // NOTE: request payload needs no reset; it is only observed qualified by req_valid.
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q  <= cpu_addr;
      wen_q   <= cpu_wen;
      wdata_q <= cpu_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_q     <= '0;
      rdata_q   <= '0;
      bus_err_q <= 1'b0;
    end else begin
      bus_err_q <= timeout;
      if (handshake)
        cnt_q <= '0;
      else if ((state == WAIT) && !resp_valid && !timeout)
        cnt_q <= cnt_q + 16'd1;
      if (resp_take)
        rdata_q <= resp_rdata;
      else if (timeout)
        rdata_q <= DATA_W'(32'hDEADBEEF);
    end
  end

  assign req_addr  = addr_q;
  assign req_wstrb = wen_q;
  assign req_wr    = posted;
  assign req_wdata = wdata_q;
  assign cpu_rdata = rdata_q;
  assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_sram_req_bridge.sv
// Directed bench for sram_req_bridge (TIMEOUT_CYC=4); read data is checked against a scoreboard
// filled when each read is issued. Honours SRAM_BRIDGE_POSTED_WRITE_EN like the RTL.
module tb_sram_req_bridge;

`ifdef SRAM_BRIDGE_POSTED_WRITE_EN
  localparam bit POSTED = 1'b1;
`else
  localparam bit POSTED = 1'b0;
`endif

  logic        clk;
  logic        resetn;
  logic        cpu_en;
  logic [3:0]  cpu_wen;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        req_valid;
  logic        req_ready;
  logic        req_wr;
  logic [3:0]  req_wstrb;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        bus_err;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] exp_q[$];

  sram_req_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(4)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .cpu_en    (cpu_en),
    .cpu_wen   (cpu_wen),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_stall (cpu_stall),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_wr    (req_wr),
    .req_wstrb (req_wstrb),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_rdata(resp_rdata),
    .bus_err   (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic sb_check(input string tag);
    logic [31:0] exp;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s observed=%0h expected=<scoreboard empty>", tag, cpu_rdata);
    end else begin
      exp = exp_q.pop_front();
      check(tag, cpu_rdata, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    resetn = 1'b0; cpu_en = 1'b0; cpu_wen = '0; cpu_addr = '0; cpu_wdata = '0;
    req_ready = 1'b0; resp_valid = 1'b0; resp_rdata = '0;
    cyc(); cyc();
    smp();
    check("rst_req_valid", req_valid, 0);
    check("rst_resp_ready", resp_ready, 0);
    check("rst_cpu_stall", cpu_stall, 0);
    check("rst_bus_err", bus_err, 0);
    check("rst_cpu_rdata", cpu_rdata, 0);
    cyc(); resetn = 1'b1;

    // Read, zero wait
    cyc();
    cpu_en = 1'b1; cpu_wen = 4'b0000; cpu_addr = 32'h1FC0_0010;
    req_ready = 1'b1; resp_valid = 1'b1; resp_rdata = 32'h1234_5678;
    exp_q.push_back(32'h1234_5678);
    smp(); check("rd0_c0_stall", cpu_stall, 1); check("rd0_c0_valid", req_valid, 0);
    cyc(); smp();
    check("rd0_c1_valid", req_valid, 1); check("rd0_c1_addr", req_addr, 32'h1FC0_0010);
    check("rd0_c1_wr", req_wr, 0); check("rd0_c1_stall", cpu_stall, 1);
    cyc(); smp();
    check("rd0_c2_resp_ready", resp_ready, 1); check("rd0_c2_stall", cpu_stall, 1);
    check("rd0_c2_valid", req_valid, 0);
    cyc(); smp();
    check("rd0_c3_stall", cpu_stall, 0); sb_check("rd0_c3_rdata");
    cyc(); cpu_en = 1'b0; resp_valid = 1'b0; req_ready = 1'b0;
    smp(); check("rd0_idle_stall", cpu_stall, 0); check("rd0_idle_resp_ready", resp_ready, 0);

    // Backpressure on a store; core inputs change after accept to prove latching
    cyc();
    cpu_en = 1'b1; cpu_wen = 4'b0011; cpu_addr = 32'h0000_0100; cpu_wdata = 32'hAAAA_5555;
    smp(); check("bp_c0_stall", cpu_stall, POSTED ? 0 : 1);
    cyc(); cpu_en = 1'b0; cpu_wen = '0; cpu_addr = '0; cpu_wdata = '0;
    for (int i = 0; i < 5; i++) begin
      smp();
      check($sformatf("bp_hold%0d_valid", i), req_valid, 1);
      check($sformatf("bp_hold%0d_wstrb", i), req_wstrb, 4'b0011);
      check($sformatf("bp_hold%0d_wdata", i), req_wdata, 32'hAAAA_5555);
      check($sformatf("bp_hold%0d_addr", i), req_addr, 32'h0000_0100);
      cyc();
    end
    req_ready = 1'b1;
    smp(); check("bp_hs_valid", req_valid, 1); check("bp_hs_wr", req_wr, 1);
    cyc(); req_ready = 1'b0; resp_valid = 1'b1; resp_rdata = 32'h0BAD_F00D;
    smp(); check("bp_wait_valid", req_valid, 0); check("bp_wait_resp_ready", resp_ready, 1);
    check("bp_wait_stall", cpu_stall, POSTED ? 0 : 1);
    cyc(); resp_valid = 1'b0;
    smp(); check("bp_done_stall", cpu_stall, 0); check("bp_done_bus_err", bus_err, 0);
    cyc();

    // Timeout: no response for 4 WAIT cycles
    cpu_en = 1'b1; cpu_wen = '0; cpu_addr = 32'h0000_0200; req_ready = 1'b1; resp_valid = 1'b0;
    exp_q.push_back(32'hDEAD_BEEF);
    cyc(); cyc();
    for (int i = 0; i < 4; i++) begin
      smp();
      check($sformatf("to_wait%0d_resp_ready", i), resp_ready, 1);
      check($sformatf("to_wait%0d_bus_err", i), bus_err, 0);
      cyc();
    end
    smp(); check("to_done_bus_err", bus_err, 1); check("to_done_stall", cpu_stall, 0);
    sb_check("to_done_rdata");
    cyc(); cpu_en = 1'b0;
    smp(); check("to_idle_bus_err", bus_err, 0); check("to_idle_resp_ready", resp_ready, 0);
    check("to_idle_valid", req_valid, 0);

    // Response in the would-be timeout cycle wins
    cyc();
    cpu_en = 1'b1; cpu_addr = 32'h0000_0204; resp_rdata = 32'hCAFE_0001;
    exp_q.push_back(32'hCAFE_0001);
    cyc(); cyc(); cyc(); cyc(); cyc();
    resp_valid = 1'b1;
    smp(); check("race_resp_ready", resp_ready, 1);
    cyc(); resp_valid = 1'b0;
    smp(); check("race_bus_err", bus_err, 0); sb_check("race_rdata");
    check("race_stall", cpu_stall, 0);
    cyc(); cpu_en = 1'b0;
    smp(); check("race_hold_rdata", cpu_rdata, 32'hCAFE_0001); check("race_idle_bus_err", bus_err, 0);

    // Reset during WAIT
    cyc();
    cpu_en = 1'b1; cpu_addr = 32'h0000_0208; req_ready = 1'b1; resp_valid = 1'b0;
    cyc(); cyc();
    smp(); check("rstw_pre_resp_ready", resp_ready, 1);
    cyc(); resetn = 1'b0; cpu_en = 1'b0;
    cyc(); resetn = 1'b1; resp_valid = 1'b1; resp_rdata = 32'h5555_5555;
    smp();
    check("rstw_valid", req_valid, 0); check("rstw_resp_ready", resp_ready, 0);
    check("rstw_rdata", cpu_rdata, 0); check("rstw_stall", cpu_stall, 0);
    cyc(); cyc();
    smp(); check("rstw_late_rdata", cpu_rdata, 0); check("rstw_late_resp_ready", resp_ready, 0);
    check("rstw_late_bus_err", bus_err, 0);
    cyc(); resp_valid = 1'b0;

    // Store followed by a load
    cpu_en = 1'b1; cpu_wen = 4'b1111; cpu_addr = 32'h0000_0300; cpu_wdata = 32'h1111_2222;
    req_ready = 1'b1; resp_valid = 1'b1; resp_rdata = 32'h0A0B_0C0D;
`ifdef SRAM_BRIDGE_POSTED_WRITE_EN
    exp_q.push_back(32'h0A0B_0C0D);
    smp(); check("pw_store_stall", cpu_stall, 0);
    cyc(); cpu_wen = 4'b0000; cpu_addr = 32'h0000_0304; cpu_wdata = '0;
    smp(); check("pw_req_stall", cpu_stall, 1); check("pw_req_addr", req_addr, 32'h0000_0300);
    check("pw_req_wr", req_wr, 1);
    cyc(); smp(); check("pw_wait_stall", cpu_stall, 1);
    cyc(); smp(); check("pw_done_stall", cpu_stall, 1);
    cyc(); smp(); check("pw_idle_stall", cpu_stall, 1);
    cyc(); smp(); check("pw_ld_addr", req_addr, 32'h0000_0304); check("pw_ld_wr", req_wr, 0);
    check("pw_ld_req_stall", cpu_stall, 1);
    cyc(); smp(); check("pw_ld_wait_stall", cpu_stall, 1);
    cyc(); smp(); check("pw_ld_done_stall", cpu_stall, 0); sb_check("pw_ld_rdata");
`else
    smp(); check("sw_c0_stall", cpu_stall, 1);
    cyc(); smp(); check("sw_c1_stall", cpu_stall, 1); check("sw_c1_wr", req_wr, 1);
    check("sw_c1_addr", req_addr, 32'h0000_0300);
    cyc(); smp(); check("sw_c2_stall", cpu_stall, 1);
    cyc(); smp(); check("sw_c3_stall", cpu_stall, 0);
`endif
    cyc(); cpu_en = 1'b0; resp_valid = 1'b0;
    smp(); check("end_idle_stall", cpu_stall, 0);
    check("sb_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
